adder_operand_ctrl: RTL



---
 rtl/adder_ctrl_pkg.sv | 14 +
 rtl/gate_hold_timer.sv | 38 +++
 rtl/adder_operand_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/adder_ctrl_pkg.sv
// rtl/adder_ctrl_pkg.sv - shared types and widths for the adder operand controller
package adder_ctrl_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int LAT_CW    = 4;
  localparam int HOLD_CW   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/gate_hold_timer.sv
// rtl/gate_hold_timer.sv - hold-window countdown that decides when a gated clock may stop
module gate_hold_timer
  import adder_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic dec_i,
  output logic expire_o
);

  logic [HOLD_CW-1:0] cnt_q, cnt_d;

  // A load (window entry or re-arm) overrides counting down; the count parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = HOLD_CW'(HOLD_CYCLES);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Countdown register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry is the edge that would consume the last remaining hold cycle.
  assign expire_o = dec_i && (cnt_q == HOLD_CW'(1));

endmodule

// File: rtl/adder_operand_ctrl.sv
// rtl/adder_operand_ctrl.sv - operand feeder and clock-gate control for the gated adder (option: OPERAND_COMPARE_EN)
module adder_operand_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int ADDER_LAT   = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             cin_out,
  output logic             cg_en,
  output logic             res_valid,
  output logic             idle
);

  localparam bit HAS_HOLD = (HOLD_CYCLES > 0);

  state_e            state_q, state_d;
  logic [LAT_CW-1:0] lat_q, lat_d;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              cin_q;
  logic              cg_q, rv_q, dup_pend_q;
  logic              accept, dup, full_acc, wait_done;
  logic              hold_load, hold_dec, hold_expire;

  assign in_ready  = (state_q != WAIT);
  assign idle      = (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign wait_done = (state_q == WAIT) && (lat_q == LAT_CW'(1));
  assign full_acc  = accept && !dup;
  assign hold_dec  = (state_q == HOLD) && !accept;

`ifdef OPERAND_COMPARE_EN
  logic last_q;

  // Remember that the operands on the adder inputs have produced a settled result.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      last_q <= 1'b0;
    end else if (wait_done) begin
      last_q <= 1'b1;
    end
  end

  assign dup = accept && last_q && (in_a == a_q) && (in_b == b_q) && (in_cin == cin_q);
`else
  assign dup = 1'b0;
`endif

  gate_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold (
    .clk     (clk),
    .rst_n   (reset_b),
    .load_i  (hold_load),
    .dec_i   (hold_dec),
    .expire_o(hold_expire)
  );

  // Next state, latency countdown and hold-window arming.
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    hold_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_acc) state_d = WAIT;
      end
      WAIT: begin
        lat_d = lat_q - 1'b1;
        if (wait_done) begin
          if (HAS_HOLD) begin
            state_d   = HOLD;
            hold_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        if (full_acc) begin
          state_d = WAIT;
        end else if (dup) begin
          hold_load = 1'b1;
        end else if (hold_expire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (full_acc) lat_d = LAT_CW'(ADDER_LAT);
  end

  // State, operand registers and registered adder controls.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      cg_q       <= 1'b0;
      rv_q       <= 1'b0;
      dup_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      cg_q       <= (state_d != IDLE);
      rv_q       <= wait_done || dup_pend_q;
      dup_pend_q <= dup;
      if (full_acc) begin
        a_q   <= in_a;
        b_q   <= in_b;
        cin_q <= in_cin;
      end
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign cin_out   = cin_q;
  assign cg_en     = cg_q;
  assign res_valid = rv_q;

endmodule
